ps2_command_transmitter: RTL

Host-to-device PS/2 transmitter for the keyboard port. Sends one command byte, e.g. 0xED (set LEDs) or 0xFF (reset), and reports ack or failure. Shares the open-drain PS2_CLK/PS2_DAT pins with the existing PS/2 receive path. It implements the host side of the PS/2 host-to-device transfer, which is the opposite direction to keyboard scan-code reception.

---
 rtl/ps2_command_transmitter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_command_transmitter.sv
// ps2_command_transmitter
//   Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
//   (inhibit, request-to-send, 8 data bits LSB first, odd parity, stop) and
//   reports ack, no-ack or timeout. Lines are open-drain: only 0 or Z driven.
//
// Ports
//   CLOCK_50                        system clock, rising edge
//   resetn                          asynchronous active-low reset
//   the_command[7:0]                byte to send, captured on acceptance
//   send_command                    level request, accepted only when idle
//   PS2_CLK, PS2_DAT                open-drain PS/2 lines (shared with rx path)
//   busy                            high whenever not idle
//   command_was_sent                1-cycle pulse, device acked
//   error_communication_timed_out   1-cycle pulse, start or transfer timeout
//   error_no_ack                    1-cycle pulse, DAT high at ack edge
//
// INHIBIT_CYCLES must be >= 2 (the last inhibit cycle overlaps REQUEST).
module ps2_command_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] the_command,
  input  logic       send_command,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out,
  output logic       error_no_ack
);

  localparam int MAX_AB = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAXC   = (MAX_AB > XFER_TIMEOUT) ? MAX_AB : XFER_TIMEOUT;
  // +2 headroom: the counter may step one past a timeout when an edge wins.
  localparam int CW     = $clog2(MAXC + 2);

  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQUEST, S_TX, S_ACK, S_RELEASE, S_DONE, S_ERROR
  } state_t;

  state_t     state, state_n;
  cnt_t       cnt, cnt_n, cnt_inc;
  logic [3:0] idx, idx_n;
  logic [9:0] frame, frame_n;
  logic       clk_low, clk_low_n;
  logic       dat_low, dat_low_n;
  logic       to_set, noack_set;

  logic [1:0] clk_sync, dat_sync;
  logic       clk_prev;
  logic       clk_s, dat_s, fall;

  // Open-drain pins: registered drive enables so reset releases instantly
  // and no decode glitch ever reaches the bus.
  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

  assign clk_s   = clk_sync[1];
  assign dat_s   = dat_sync[1];
  assign fall    = clk_prev & ~clk_s;
  assign cnt_inc = cnt + cnt_t'(1);
  assign busy    = (state != S_IDLE);

  // Synchronizers reset to the idle (pulled-up) level so reset release
  // does not fabricate a falling edge.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
      clk_prev <= clk_s;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state                         <= S_IDLE;
      cnt                           <= '0;
      idx                           <= '0;
      frame                         <= '0;
      clk_low                       <= 1'b0;
      dat_low                       <= 1'b0;
      command_was_sent              <= 1'b0;
      error_communication_timed_out <= 1'b0;
      error_no_ack                  <= 1'b0;
    end else begin
      state                         <= state_n;
      cnt                           <= cnt_n;
      idx                           <= idx_n;
      frame                         <= frame_n;
      clk_low                       <= clk_low_n;
      dat_low                       <= dat_low_n;
      command_was_sent              <= (state_n == S_DONE);
      error_communication_timed_out <= to_set;
      error_no_ack                  <= noack_set;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    frame_n   = frame;
    clk_low_n = clk_low;
    dat_low_n = dat_low;
    to_set    = 1'b0;
    noack_set = 1'b0;

    case (state)
      S_IDLE: begin
        clk_low_n = 1'b0;
        dat_low_n = 1'b0;
        if (send_command) begin
          // frame = {stop, odd parity, data}; shifted out from bit 0.
          frame_n   = {1'b1, ~^the_command, the_command};
          cnt_n     = '0;
          idx_n     = '0;
          clk_low_n = 1'b1;
          state_n   = S_INHIBIT;
        end
      end

      // INHIBIT holds N-1 cycles; CLK stays low through the first REQUEST
      // cycle as well, giving exactly N low cycles with DAT already low in
      // the last one.
      S_INHIBIT: begin
        cnt_n = cnt_inc;
        if (cnt_inc == cnt_t'(INHIBIT_CYCLES - 1)) begin
          cnt_n     = '0;
          dat_low_n = 1'b1;
          state_n   = S_REQUEST;
        end
      end

      S_REQUEST: begin
        clk_low_n = 1'b0;
        if (fall) begin
          dat_low_n = ~frame[0];
          idx_n     = 4'd1;
          cnt_n     = '0;
          state_n   = S_TX;
        end else if (cnt_inc >= cnt_t'(START_TIMEOUT)) begin
          dat_low_n = 1'b0;
          to_set    = 1'b1;
          state_n   = S_ERROR;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      // Edge k (k=2..10) presents frame[k-1]; frame[9] is the stop bit (1),
      // which releases DAT as the transfer moves to ACK.
      S_TX: begin
        cnt_n = cnt_inc;
        if (fall) begin
          dat_low_n = ~frame[idx];
          idx_n     = idx + 4'd1;
          if (idx == 4'd9) state_n = S_ACK;
        end else if (cnt_inc >= cnt_t'(XFER_TIMEOUT)) begin
          dat_low_n = 1'b0;
          to_set    = 1'b1;
          state_n   = S_ERROR;
        end
      end

      S_ACK: begin
        cnt_n = cnt_inc;
        if (fall) begin
          if (!dat_s) begin
            state_n = S_RELEASE;
          end else begin
            noack_set = 1'b1;
            state_n   = S_ERROR;
          end
        end else if (cnt_inc >= cnt_t'(XFER_TIMEOUT)) begin
          to_set  = 1'b1;
          state_n = S_ERROR;
        end
      end

      S_RELEASE: begin
        cnt_n = cnt_inc;
        if (clk_s && dat_s) begin
          state_n = S_DONE;
        end else if (cnt_inc >= cnt_t'(XFER_TIMEOUT)) begin
          to_set  = 1'b1;
          state_n = S_ERROR;
        end
      end

      S_DONE: begin
        clk_low_n = 1'b0;
        dat_low_n = 1'b0;
        state_n   = S_IDLE;
      end

      S_ERROR: begin
        clk_low_n = 1'b0;
        dat_low_n = 1'b0;
        state_n   = S_IDLE;
      end

      default: begin
        clk_low_n = 1'b0;
        dat_low_n = 1'b0;
        state_n   = S_IDLE;
      end
    endcase
  end

endmodule
